// File: rtl/sdram_port_arbiter.sv
// Multi-port front end for a single SDRAM controller command port.
// Arbitrates requesters, registers the winning command and routes in-order read data back by tag.
module sdram_port_arbiter #(
    parameter int NUM_PORTS  = 3,
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 16,
    parameter int MODE       = 0,
    parameter int PEND_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_PORTS-1:0]              req_valid,
    output logic [NUM_PORTS-1:0]              req_ready,
    input  logic [NUM_PORTS-1:0]              req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   req_wdata,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] req_wmask,
    output logic [NUM_PORTS-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]             rsp_rdata,
    output logic                              mem_valid,
    input  logic                              mem_ready,
    output logic                              mem_write,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [DATA_WIDTH-1:0]             mem_wdata,
    output logic [DATA_WIDTH/8-1:0]           mem_wmask,
    input  logic                              mem_rvalid,
    input  logic [DATA_WIDTH-1:0]             mem_rdata,
    output logic                              overflow_err
);

    localparam int MASK_W = DATA_WIDTH / 8;
    localparam int TAG_W  = $clog2(NUM_PORTS);
    localparam int PTR_W  = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;
    localparam int CNT_W  = $clog2(PEND_DEPTH + 1);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                  state_reg;
    logic [TAG_W-1:0]        last_grant_reg;
    logic                    mem_valid_reg;
    logic                    mem_write_reg;
    logic [ADDR_WIDTH-1:0]   mem_addr_reg;
    logic [DATA_WIDTH-1:0]   mem_wdata_reg;
    logic [MASK_W-1:0]       mem_wmask_reg;
    logic [NUM_PORTS-1:0]    rsp_valid_reg;
    logic [DATA_WIDTH-1:0]   rsp_rdata_reg;
    logic                    overflow_reg;

    logic [TAG_W-1:0]        tag_mem [PEND_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_reg;
    logic [PTR_W-1:0]        rd_ptr_reg;
    logic [CNT_W-1:0]        count_reg;

    logic [ADDR_WIDTH-1:0]   addr_arr  [NUM_PORTS];
    logic [DATA_WIDTH-1:0]   wdata_arr [NUM_PORTS];
    logic [MASK_W-1:0]       wmask_arr [NUM_PORTS];
    logic [NUM_PORTS-1:0]    eligible;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    grant_found;
    logic [TAG_W-1:0]        grant_idx;
    logic [TAG_W-1:0]        cand;
    int                      idx;
    logic                    do_grant;
    logic                    grant_read;
    logic                    do_pop;
    logic [TAG_W-1:0]        head_tag;

    assign fifo_full  = (count_reg == CNT_W'(PEND_DEPTH));
    assign fifo_empty = (count_reg == '0);
    assign head_tag   = tag_mem[rd_ptr_reg];

    // Reads need a free tag slot; writes never wait on the tag FIFO.
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign wmask_arr[gi] = req_wmask[gi*MASK_W +: MASK_W];
            assign eligible[gi]  = req_valid[gi] && (req_write[gi] || !fifo_full);
            assign req_ready[gi] = do_grant && (grant_idx == TAG_W'(gi));
        end
    endgenerate

    // Both searches run in reverse so the last hit is the first port in priority order.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        idx         = 0;
        if (MODE == 1) begin
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (eligible[i]) begin
                    grant_found = 1'b1;
                    grant_idx   = TAG_W'(i);
                end
            end
        end else begin
            for (int k = NUM_PORTS; k >= 1; k--) begin
                idx = int'(last_grant_reg) + k;
                if (idx >= NUM_PORTS) begin
                    idx = idx - NUM_PORTS;
                end
                cand = TAG_W'(idx);
                if (eligible[cand]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
    end

    assign do_grant   = (state_reg == IDLE) && grant_found && !reset;
    assign grant_read = do_grant && !req_write[grant_idx];
    assign do_pop     = mem_rvalid && !fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= TAG_W'(NUM_PORTS - 1);
            mem_valid_reg  <= 1'b0;
            mem_write_reg  <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            mem_wmask_reg  <= '0;
            rsp_valid_reg  <= '0;
            rsp_rdata_reg  <= '0;
            overflow_reg   <= 1'b0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (do_grant) begin
                        state_reg      <= ISSUE;
                        last_grant_reg <= grant_idx;
                        mem_valid_reg  <= 1'b1;
                        mem_write_reg  <= req_write[grant_idx];
                        mem_addr_reg   <= addr_arr[grant_idx];
                        mem_wdata_reg  <= wdata_arr[grant_idx];
                        mem_wmask_reg  <= wmask_arr[grant_idx];
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        state_reg     <= IDLE;
                        mem_valid_reg <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            if (grant_read) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(PEND_DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(PEND_DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
            end
            case ({grant_read, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase

            if (do_pop) begin
                rsp_valid_reg <= NUM_PORTS'(1) << head_tag;
                rsp_rdata_reg <= mem_rdata;
            end else begin
                rsp_valid_reg <= '0;
            end

            if (mem_rvalid && fifo_empty) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset: occupancy and pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (grant_read) begin
            tag_mem[wr_ptr_reg] <= grant_idx;
        end
    end

    assign mem_valid    = mem_valid_reg;
    assign mem_write    = mem_write_reg;
    assign mem_addr     = mem_addr_reg;
    assign mem_wdata    = mem_wdata_reg;
    assign mem_wmask    = mem_wmask_reg;
    assign rsp_valid    = rsp_valid_reg;
    assign rsp_rdata    = rsp_rdata_reg;
    assign overflow_err = overflow_reg;

endmodule
